reg_bus_arbiter: RTL and testbench
==================================

Name: reg_bus_arbiter

Overview:
- Write-side controller for a bank of reg8 registers that share one 8-bit data bus.
- Arbitrates between two requesters, A and B, each issuing single commands:
  - LOAD: write an immediate into a register.
  - MOVE: copy one register into another.
- Drives the shared d bus and per-register write enables; reads register outputs back for MOVE.
- Sits between the control unit / debug port and the register bank.

Parameters:
- NUM_REGS, 4, number of reg8 instances controlled (2..16).
- AW, 2, register index width; must satisfy 2**AW >= NUM_REGS.

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_ni  in  1  asynchronous active-low reset.
- a_req_i  in  1  requester A command valid.
- a_op_i  in  1  A op: 0=LOAD, 1=MOVE.
- a_dst_i  in  AW  A destination register index.
- a_src_i  in  AW  A source index (MOVE only).
- a_data_i  in  8  A immediate (LOAD only).
- a_gnt_o  out  1  one-cycle pulse: A command accepted.
- a_done_o  out  1  one-cycle pulse: A command completed.
- b_req_i, b_op_i, b_dst_i, b_src_i, b_data_i, b_gnt_o, b_done_o: same as A, for requester B.
- reg_q_i  in  NUM_REGS*8  concatenated reg8 q_o outputs; register n at bits [8n+7:8n].
- reg_d_o  out  8  shared bus to every reg8 d_i.
- reg_wen_o  out  NUM_REGS  one-hot write enables to reg8 wen_i.
- busy_o  out  1  high whenever state != IDLE.

Behaviour:
- Reset (asynchronous, rst_ni low):
  - state=IDLE; all outputs 0; latched command cleared; last_grant=B, so A wins the first tie.
  - Reset mid-operation aborts the command: no wen, no done, no gnt after release.
- States: IDLE, FETCH, WRITE.
- Outputs reg_wen_o, reg_d_o and busy_o are decoded from registered state and latched command only. No combinational path from any *_req_i.
- IDLE:
  - At an edge with any req high, pick a winner:
    - Only one req high: that requester wins.
    - Both high: the requester not equal to last_grant wins (round-robin).
  - On acceptance: latch op/dst/src/data of the winner, set last_grant, and pulse winner's gnt_o high for the next cycle.
  - Next state: FETCH if MOVE, WRITE if LOAD.
- FETCH (1 cycle):
  - reg_wen_o=0.
  - At the edge, latch reg_q_i[src] into the data register; next state WRITE.
- WRITE (1 cycle):
  - reg_d_o = latched data; reg_wen_o = one-hot(dst). The reg8 captures at the closing edge.
  - At that edge: state→IDLE; winner's done_o high for the following cycle.
- Latency from the acceptance edge E0:
  - LOAD: gnt and wen in cycle 1; done in cycle 2.
  - MOVE: gnt in cycle 1 (FETCH); wen in cycle 2; done in cycle 3.
- Back-to-back: a new request may be accepted at the edge ending the done cycle. Throughput is 1 LOAD per 2 cycles, 1 MOVE per 3 cycles.
- Request fields are sampled only at the acceptance edge and may change afterwards. A req still high in IDLE after done counts as a new request.
- reg_d_o holds its last value outside WRITE; it is only meaningful while a wen bit is high.
- MOVE with src==dst: executes normally; register value unchanged.
- dst >= NUM_REGS: reg_wen_o stays all-zero; done still pulses.
- src >= NUM_REGS: fetched data reads as 0x00.
- gnt_o and done_o of A and B are never high in the same cycle. At most one reg_wen_o bit is ever high.

Optional Feature:
- Macro REG_ARB_FIXED_PRIO_EN.
- Defined: A always wins when both request; last_grant is ignored. B can be starved, which is intended for the debug-halt use.
- Undefined (default): round-robin as in Behaviour.

Test Plan:
- Reset mid-operation: accept A MOVE, pull rst_ni low during FETCH, release → all outputs 0 and no wen/done afterwards.
- A LOAD dst=2 data=0xCC → a_gnt_o and reg_wen_o=4'b0100 with reg_d_o=0xCC in cycle 1; a_done_o in cycle 2; reg2 q=0xCC; then IDLE with busy_o=0.
- After the LOAD, B MOVE src=2 dst=0 → b_gnt_o in cycle 1 with wen=0; cycle 2 reg_wen_o=4'b0001, reg_d_o=0xCC; b_done_o in cycle 3; reg0=0xCC.
- A and B both hold LOAD requests (A dst=1 0x11, B dst=3 0x33) continuously from reset → grants alternate A,B,A,B; reg1=0x11, reg3=0x33; gnt/done never overlap.
- NUM_REGS=3, A LOAD dst=3 → reg_wen_o stays 3'b000, a_done_o pulses; MOVE src=3 dst=0 writes 0x00 into reg0.
- With REG_ARB_FIXED_PRIO_EN defined, A and B requesting continuously for 10 commands → only a_gnt_o pulses; b_gnt_o is granted only after a_req_i drops.

Source files
------------

// File: rtl/reg_bus_arbiter.sv
`timescale 1ns/1ps
// Write-side arbiter for a bank of reg8 registers sharing one data bus (LOAD / MOVE from A and B).
// Define REG_ARB_FIXED_PRIO_EN to let A win every tie; otherwise ties are resolved round-robin.
module reg_bus_arbiter #(
  parameter int NUM_REGS = 4,
  parameter int AW       = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  a_req_i,
  input  logic                  a_op_i,
  input  logic [AW-1:0]         a_dst_i,
  input  logic [AW-1:0]         a_src_i,
  input  logic [7:0]            a_data_i,
  output logic                  a_gnt_o,
  output logic                  a_done_o,
  input  logic                  b_req_i,
  input  logic                  b_op_i,
  input  logic [AW-1:0]         b_dst_i,
  input  logic [AW-1:0]         b_src_i,
  input  logic [7:0]            b_data_i,
  output logic                  b_gnt_o,
  output logic                  b_done_o,
  input  logic [NUM_REGS*8-1:0] reg_q_i,
  output logic [7:0]            reg_d_o,
  output logic [NUM_REGS-1:0]   reg_wen_o,
  output logic                  busy_o
);

  typedef enum logic [1:0] {IDLE, FETCH, WRITE} state_t;

  state_t        r_state;
  state_t        w_next;
  logic          r_owner_b;
  logic [AW-1:0] r_dst;
  logic [AW-1:0] r_src;
  logic [7:0]    r_data;
  logic          r_a_gnt;
  logic          r_b_gnt;
  logic          r_a_done;
  logic          r_b_done;
  logic          w_accept;
  logic          w_pick_b;
  logic          w_op;
  logic [7:0]    w_fetch;
`ifndef REG_ARB_FIXED_PRIO_EN
  logic          r_last_b;
`endif

  always_comb begin
    w_pick_b = b_req_i;
    if (a_req_i && b_req_i) begin
`ifdef REG_ARB_FIXED_PRIO_EN
      w_pick_b = 1'b0;
`else
      w_pick_b = ~r_last_b;
`endif
    end
  end

  assign w_accept = (r_state == IDLE) && (a_req_i || b_req_i);
  assign w_op     = w_pick_b ? b_op_i : a_op_i;

  // Source indices beyond the bank read as zero.
  always_comb begin
    w_fetch = 8'h00;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (r_src == AW'(i)) w_fetch = reg_q_i[8*i +: 8];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next = w_op ? FETCH : WRITE;
      FETCH:   w_next = WRITE;
      WRITE:   w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // r_data only changes on edges entering WRITE, so the bus holds its value elsewhere.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_owner_b <= 1'b0;
      r_dst     <= '0;
      r_src     <= '0;
      r_data    <= 8'h00;
      r_a_gnt   <= 1'b0;
      r_b_gnt   <= 1'b0;
      r_a_done  <= 1'b0;
      r_b_done  <= 1'b0;
`ifndef REG_ARB_FIXED_PRIO_EN
      r_last_b  <= 1'b1;
`endif
    end else begin
      r_a_gnt  <= w_accept && !w_pick_b;
      r_b_gnt  <= w_accept &&  w_pick_b;
      r_a_done <= (r_state == WRITE) && !r_owner_b;
      r_b_done <= (r_state == WRITE) &&  r_owner_b;
      if (w_accept) begin
        r_owner_b <= w_pick_b;
`ifndef REG_ARB_FIXED_PRIO_EN
        r_last_b  <= w_pick_b;
`endif
        r_dst     <= w_pick_b ? b_dst_i : a_dst_i;
        r_src     <= w_pick_b ? b_src_i : a_src_i;
        if (!w_op) r_data <= w_pick_b ? b_data_i : a_data_i;
      end
      if (r_state == FETCH) r_data <= w_fetch;
    end
  end

  always_comb begin
    reg_wen_o = '0;
    busy_o    = (r_state != IDLE);
    if (r_state == WRITE) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (r_dst == AW'(i)) reg_wen_o[i] = 1'b1;
      end
    end
  end

  assign reg_d_o  = r_data;
  assign a_gnt_o  = r_a_gnt;
  assign b_gnt_o  = r_b_gnt;
  assign a_done_o = r_a_done;
  assign b_done_o = r_b_done;

endmodule

// File: tb/tb_reg_bus_arbiter.sv
`timescale 1ns/1ps
// Self-checking bench for reg_bus_arbiter: emulates the reg8 bank and predicts every cycle
// from a transaction-level model of the LOAD/MOVE rules and the arbitration policy.
module tb_reg_bus_arbiter;

  localparam int N  = 4;
  localparam int AW = 3;

  typedef struct packed {
    logic          op;
    logic [AW-1:0] dst;
    logic [AW-1:0] src;
    logic [7:0]    data;
  } cmd_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic a_req = 1'b0, a_op = 1'b0, b_req = 1'b0, b_op = 1'b0;
  logic [AW-1:0] a_dst = '0, a_src = '0, b_dst = '0, b_src = '0;
  logic [7:0] a_data = 8'h00, b_data = 8'h00;
  logic a_gnt, a_done, b_gnt, b_done, busy;
  logic [7:0] reg_d;
  logic [N-1:0] reg_wen;
  logic [N*8-1:0] reg_q;
  logic [7:0] bank [N];
  logic [7:0] model [N];
  bit lastB = 1'b1;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  reg_bus_arbiter #(.NUM_REGS(N), .AW(AW)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .a_req_i(a_req), .a_op_i(a_op), .a_dst_i(a_dst), .a_src_i(a_src), .a_data_i(a_data),
    .a_gnt_o(a_gnt), .a_done_o(a_done),
    .b_req_i(b_req), .b_op_i(b_op), .b_dst_i(b_dst), .b_src_i(b_src), .b_data_i(b_data),
    .b_gnt_o(b_gnt), .b_done_o(b_done),
    .reg_q_i(reg_q), .reg_d_o(reg_d), .reg_wen_o(reg_wen), .busy_o(busy)
  );

  // Behavioural reg8 bank driven by the arbiter.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) bank[i] <= 8'h00;
    end else begin
      for (int i = 0; i < N; i++) if (reg_wen[i]) bank[i] <= reg_d;
    end
  end

  for (genvar g = 0; g < N; g++) begin : g_q
    assign reg_q[8*g +: 8] = bank[g];
  end

  function automatic bit pickB(bit aR, bit bR, bit lastWasB);
    if (aR && bR) begin
`ifdef REG_ARB_FIXED_PRIO_EN
      return 1'b0;
`else
      return !lastWasB;
`endif
    end
    return bR;
  endfunction

  function automatic logic [N-1:0] wenFor(logic [AW-1:0] dst);
    return (int'(dst) < N) ? (N'(1) << dst) : '0;
  endfunction

  function automatic logic [N+4:0] observed();
    return {a_gnt, b_gnt, a_done, b_done, busy, reg_wen};
  endfunction

  task automatic clearModel();
    for (int i = 0; i < N; i++) model[i] = 8'h00;
    lastB = 1'b1;
  endtask

  // Drive one arbitration round at a negedge with the DUT idle; returns at the negedge of the done cycle.
  task automatic applyStimulus(input string name, input bit aR, input cmd_t aC, input bit bR, input cmd_t bC);
    bit wB;
    cmd_t c;
    logic [7:0] val;
    logic [N-1:0] we;
    logic [N+4:0] e;
    wB = pickB(aR, bR, lastB);
    lastB = wB;
    c = wB ? bC : aC;
    val = c.op ? ((int'(c.src) < N) ? model[c.src[1:0]] : 8'h00) : c.data;
    we = wenFor(c.dst);
    a_req = aR; a_op = aC.op; a_dst = aC.dst; a_src = aC.src; a_data = aC.data;
    b_req = bR; b_op = bC.op; b_dst = bC.dst; b_src = bC.src; b_data = bC.data;
    @(posedge clk);
    #1;
    a_req = 1'b0; a_op = 1'($urandom); a_dst = AW'($urandom); a_src = AW'($urandom); a_data = 8'($urandom);
    b_req = 1'b0; b_op = 1'($urandom); b_dst = AW'($urandom); b_src = AW'($urandom); b_data = 8'($urandom);
    @(negedge clk);
    e = {!wB, wB, 2'b00, 1'b1, (c.op ? {N{1'b0}} : we)};
    checks++;
    if (observed() !== e) begin
      failures++;
      $display("[TB] FAIL %s grant cycle: got %b expected %b", name, observed(), e);
    end
    if (!c.op && we != '0) begin
      checks++;
      if (reg_d !== val) begin
        failures++;
        $display("[TB] FAIL %s load data: got %h expected %h", name, reg_d, val);
      end
    end
    if (c.op) begin
      @(negedge clk);
      e = {4'b0000, 1'b1, we};
      checks++;
      if (observed() !== e) begin
        failures++;
        $display("[TB] FAIL %s move write cycle: got %b expected %b", name, observed(), e);
      end
      if (we != '0) begin
        checks++;
        if (reg_d !== val) begin
          failures++;
          $display("[TB] FAIL %s move data: got %h expected %h", name, reg_d, val);
        end
      end
    end
    @(negedge clk);
    e = {2'b00, !wB, wB, 1'b0, {N{1'b0}}};
    checks++;
    if (observed() !== e) begin
      failures++;
      $display("[TB] FAIL %s done cycle: got %b expected %b", name, observed(), e);
    end
    if (int'(c.dst) < N) model[c.dst[1:0]] = val;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    checks++;
    if (observed() !== '0 || reg_d !== 8'h00) begin
      failures++;
      $display("[TB] FAIL reset outputs: got %b/%h expected all zero", observed(), reg_d);
    end
    @(negedge clk);
    rst_n = 1'b1;
    clearModel();
  endtask

  task automatic test_load_move();
    applyStimulus("loadA", 1'b1, '{op:1'b0, dst:3'd2, src:3'd0, data:8'hCC}, 1'b0, '0);
    checks++;
    if (bank[2] !== 8'hCC) begin
      failures++;
      $display("[TB] FAIL load reg2: got %h expected cc", bank[2]);
    end
    applyStimulus("moveB", 1'b0, '0, 1'b1, '{op:1'b1, dst:3'd0, src:3'd2, data:8'h5A});
    checks++;
    if (bank[0] !== 8'hCC) begin
      failures++;
      $display("[TB] FAIL move reg0: got %h expected cc", bank[0]);
    end
  endtask

  task automatic test_out_of_range();
    applyStimulus("loadDst5", 1'b1, '{op:1'b0, dst:3'd5, src:3'd0, data:8'hAA}, 1'b0, '0);
    applyStimulus("moveSrc6", 1'b1, '{op:1'b1, dst:3'd0, src:3'd6, data:8'h77}, 1'b0, '0);
    checks++;
    if (bank[0] !== 8'h00) begin
      failures++;
      $display("[TB] FAIL out-of-range src: got %h expected 00", bank[0]);
    end
    applyStimulus("moveSelf", 1'b0, '0, 1'b1, '{op:1'b1, dst:3'd2, src:3'd2, data:8'h00});
    checks++;
    if (bank[2] !== 8'hCC) begin
      failures++;
      $display("[TB] FAIL self move: got %h expected cc", bank[2]);
    end
  endtask

  task automatic test_reset_mid_op();
    a_req = 1'b1; a_op = 1'b1; a_dst = 3'd1; a_src = 3'd2; a_data = 8'h00;
    @(posedge clk);
    #1;
    a_req = 1'b0;
    @(negedge clk);
    checks++;
    if (a_gnt !== 1'b1 || busy !== 1'b1) begin
      failures++;
      $display("[TB] FAIL midop fetch: got gnt=%b busy=%b expected 1 1", a_gnt, busy);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (observed() !== '0 || reg_d !== 8'h00) begin
      failures++;
      $display("[TB] FAIL midop async reset: got %b/%h expected all zero", observed(), reg_d);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    clearModel();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++;
      if (observed() !== '0) begin
        failures++;
        $display("[TB] FAIL midop after release %0d: got %b expected all zero", k, observed());
      end
    end
  endtask

  task automatic test_round_robin();
    bit wB;
    logic [AW-1:0] dst;
    logic [7:0] data;
    a_req = 1'b1; a_op = 1'b0; a_dst = 3'd1; a_src = 3'd0; a_data = 8'h11;
    b_req = 1'b1; b_op = 1'b0; b_dst = 3'd3; b_src = 3'd0; b_data = 8'h33;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    clearModel();
    for (int k = 0; k < 8; k++) begin
      wB = pickB(1'b1, 1'b1, lastB);
      lastB = wB;
      dst = wB ? 3'd3 : 3'd1;
      data = wB ? 8'h33 : 8'h11;
      @(negedge clk);
      checks++;
      if (observed() !== {!wB, wB, 3'b001, wenFor(dst)} || reg_d !== data) begin
        failures++;
        $display("[TB] FAIL rr grant %0d: got %b/%h expected %b/%h", k, observed(), reg_d, {!wB, wB, 3'b001, wenFor(dst)}, data);
      end
      @(negedge clk);
      checks++;
      if (observed() !== {2'b00, !wB, wB, 1'b0, {N{1'b0}}}) begin
        failures++;
        $display("[TB] FAIL rr done %0d: got %b expected %b", k, observed(), {2'b00, !wB, wB, 1'b0, {N{1'b0}}});
      end
      model[dst[1:0]] = data;
      if (k == 7) begin
        a_req = 1'b0;
        b_req = 1'b0;
      end
    end
    for (int i = 0; i < N; i++) begin
      checks++;
      if (bank[i] !== model[i]) begin
        failures++;
        $display("[TB] FAIL rr reg%0d: got %h expected %h", i, bank[i], model[i]);
      end
    end
  endtask

  task automatic test_random();
    cmd_t ca, cb;
    int pat;
    for (int k = 0; k < 40; k++) begin
      ca = '{op:1'($urandom), dst:AW'($urandom_range(0, 5)), src:AW'($urandom_range(0, 5)), data:8'($urandom)};
      cb = '{op:1'($urandom), dst:AW'($urandom_range(0, 5)), src:AW'($urandom_range(0, 5)), data:8'($urandom)};
      pat = $urandom_range(0, 2);
      applyStimulus($sformatf("rand%0d", k), pat != 1, ca, pat != 0, cb);
    end
    for (int i = 0; i < N; i++) begin
      checks++;
      if (bank[i] !== model[i]) begin
        failures++;
        $display("[TB] FAIL random reg%0d: got %h expected %h", i, bank[i], model[i]);
      end
    end
  endtask

  initial begin
    $display("[TB] starting reg_bus_arbiter bench");
    test_reset();
    test_load_move();
    test_out_of_range();
    test_reset_mid_op();
    test_round_robin();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
